// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - MM:SS preset countdown timer with debounced keys, 7-seg display and alarm LEDs
module countdown_timer #(
    parameter int TICK_DIV        = 500000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_TICKS     = 25
) (
    input  logic       CLOCK_50,
    input  logic       key_reset,
    input  logic       key_start_pause,
    input  logic       key_set_min,
    input  logic       key_set_sec,
    output logic [6:0] hex5,
    output logic [6:0] hex4,
    output logic [6:0] hex3,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic       led0,
    output logic       led1,
    output logic       led2,
    output logic       led3
);

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);
    localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;

    // key index: 2 = start_pause, 1 = set_min, 0 = set_sec
    logic [2:0]    key_raw;
    logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]    db_q, db_d, press_q, press_d;
    logic [DW-1:0] db_cnt_q [3];
    logic [DW-1:0] db_cnt_d [3];

    state_t        state_q, state_d;
    logic [15:0]   preset_q, preset_d;
    logic [23:0]   cnt_q, cnt_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [3:0]    led_q, led_d;
    logic          tick;
    logic          led3_d;
    logic [23:0]   disp;

    assign key_raw = {key_start_pause, key_set_min, key_set_sec};

    function automatic logic [7:0] inc59(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Digit order low to high: CC units, CC tens, SS units, SS tens, MM units, MM tens
    function automatic logic [23:0] bcd_dec(input logic [23:0] v);
        logic [23:0] r;
        logic        borrow;
        logic [3:0]  d;
        logic [3:0]  lim;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d   = v[i*4 +: 4];
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (borrow) begin
                if (d == 4'd0) begin
                    r[i*4 +: 4] = lim;
                end else begin
                    r[i*4 +: 4] = d - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
        for (int i = 0; i < 3; i++) begin
            db_d[i]     = db_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_MAX) db_d[i] = sync2_q[i];
                else                       db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
        press_d = db_q & ~db_d;
    end

    always_comb begin
        state_d     = state_q;
        preset_d    = preset_q;
        cnt_d       = cnt_q;
        tick_cnt_d  = '0;
        blink_cnt_d = blink_cnt_q;
        led3_d      = 1'b0;
        tick        = (tick_cnt_q == TICK_MAX);
        case (state_q)
            S_IDLE: begin
                if (press_q[2]) begin
                    if (preset_q != 16'h0000) begin
                        cnt_d   = {preset_q, 8'h00};
                        state_d = S_RUN;
                    end
                end else begin
                    if (press_q[1]) preset_d[15:8] = inc59(preset_q[15:8]);
                    if (press_q[0]) preset_d[7:0]  = inc59(preset_q[7:0]);
                end
            end
            S_RUN: begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
                if (press_q[2]) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    cnt_d = bcd_dec(cnt_q);
                    if (cnt_d == 24'h0) begin
                        state_d     = S_EXPIRED;
                        blink_cnt_d = '0;
                        led3_d      = 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                if (press_q[2]) state_d = S_RUN;
            end
            S_EXPIRED: begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
                led3_d     = led_q[3];
                if (press_q[2]) begin
                    state_d     = S_IDLE;
                    blink_cnt_d = '0;
                    led3_d      = 1'b0;
                end else if (tick) begin
                    if (blink_cnt_q == BLINK_MAX) begin
                        blink_cnt_d = '0;
                        led3_d      = ~led_q[3];
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        led_d = {led3_d, state_d == S_EXPIRED, state_d == S_PAUSE, state_d == S_RUN};
    end

    always_ff @(posedge CLOCK_50 or negedge key_reset) begin
        if (!key_reset) begin
            sync1_q     <= 3'b111;
            sync2_q     <= 3'b111;
            db_q        <= 3'b111;
            press_q     <= 3'b000;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
            state_q     <= S_IDLE;
            preset_q    <= '0;
            cnt_q       <= '0;
            tick_cnt_q  <= '0;
            blink_cnt_q <= '0;
            led_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            press_q     <= press_d;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
            state_q     <= state_d;
            preset_q    <= preset_d;
            cnt_q       <= cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            led_q       <= led_d;
        end
    end

    assign disp = (state_q == S_IDLE) ? {preset_q, 8'h00} : cnt_q;
    assign hex5 = seg(disp[23:20]);
    assign hex4 = seg(disp[19:16]);
    assign hex3 = seg(disp[15:12]);
    assign hex2 = seg(disp[11:8]);
    assign hex1 = seg(disp[7:4]);
    assign hex0 = seg(disp[3:0]);
    assign led0 = led_q[0];
    assign led1 = led_q[1];
    assign led2 = led_q[2];
    assign led3 = led_q[3];

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed self-checking bench for countdown_timer
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       k_reset = 1'b0;
    logic       k_start = 1'b1;
    logic       k_min = 1'b1;
    logic       k_sec = 1'b1;
    logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
    logic       led0, led1, led2, led3;
    int         checks = 0;
    int         errors = 0;

    wire [41:0] disp_w = {hex5, hex4, hex3, hex2, hex1, hex0};
    wire [3:0]  leds_w = {led3, led2, led1, led0};

    countdown_timer #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3), .BLINK_TICKS(2)) dut (
        .CLOCK_50(clk), .key_reset(k_reset), .key_start_pause(k_start),
        .key_set_min(k_min), .key_set_sec(k_sec),
        .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .led0(led0), .led1(led1), .led2(led2), .led3(led3)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] disp(input int mm, input int ss, input int cc);
        return {seg(mm / 10), seg(mm % 10), seg(ss / 10), seg(ss % 10), seg(cc / 10), seg(cc % 10)};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds the keys low long enough to debounce; returns on the negedge after the FSM acted.
    task automatic press(input logic [2:0] m);
        @(negedge clk);
        if (m[2]) k_start = 1'b0;
        if (m[1]) k_min = 1'b0;
        if (m[0]) k_sec = 1'b0;
        repeat (6) @(negedge clk);
        k_start = 1'b1;
        k_min   = 1'b1;
        k_sec   = 1'b1;
    endtask

    task automatic do_reset();
        k_reset = 1'b0;
        cycles(3);
        k_reset = 1'b1;
        cycles(2);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (disp_w !== disp(0, 0, 0)) begin
            errors++; $display("FAIL reset_display got %h exp %h", disp_w, disp(0, 0, 0));
        end
        checks++;
        if (leds_w !== 4'b0000) begin
            errors++; $display("FAIL reset_leds got %b exp %b", leds_w, 4'b0000);
        end
    endtask

    task automatic test_set();
        do_reset();
        for (int i = 0; i < 5; i++) begin press(3'b001); cycles(6); end
        for (int i = 0; i < 2; i++) begin press(3'b010); cycles(6); end
        checks++;
        if (disp_w !== disp(2, 5, 0)) begin
            errors++; $display("FAIL set_display got %h exp %h", disp_w, disp(2, 5, 0));
        end
        checks++;
        if (leds_w !== 4'b0000) begin
            errors++; $display("FAIL set_leds got %b exp %b", leds_w, 4'b0000);
        end
        @(negedge clk); k_sec = 1'b0;
        cycles(2); k_sec = 1'b1;
        cycles(10);
        checks++;
        if (disp_w !== disp(2, 5, 0)) begin
            errors++; $display("FAIL glitch_display got %h exp %h", disp_w, disp(2, 5, 0));
        end
        press(3'b011); cycles(6);
        checks++;
        if (disp_w !== disp(3, 6, 0)) begin
            errors++; $display("FAIL both_keys got %h exp %h", disp_w, disp(3, 6, 0));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 61; i++) begin press(3'b001); cycles(6); end
        checks++;
        if (disp_w !== disp(0, 1, 0)) begin
            errors++; $display("FAIL sec_wrap got %h exp %h", disp_w, disp(0, 1, 0));
        end
        for (int i = 0; i < 59; i++) begin press(3'b010); cycles(6); end
        checks++;
        if (disp_w !== disp(59, 1, 0)) begin
            errors++; $display("FAIL min_59 got %h exp %h", disp_w, disp(59, 1, 0));
        end
        press(3'b010); cycles(6);
        checks++;
        if (disp_w !== disp(0, 1, 0)) begin
            errors++; $display("FAIL min_wrap got %h exp %h", disp_w, disp(0, 1, 0));
        end
        do_reset();
        press(3'b100); cycles(10);
        checks++;
        if (leds_w !== 4'b0000) begin
            errors++; $display("FAIL zero_start_leds got %b exp %b", leds_w, 4'b0000);
        end
        checks++;
        if (disp_w !== disp(0, 0, 0)) begin
            errors++; $display("FAIL zero_start_display got %h exp %h", disp_w, disp(0, 0, 0));
        end
    endtask

    task automatic test_countdown();
        do_reset();
        press(3'b001); cycles(6);
        press(3'b100);
        checks++;
        if (leds_w !== 4'b0001 || disp_w !== disp(0, 1, 0)) begin
            errors++; $display("FAIL run_entry got leds %b disp %h exp leds %b disp %h", leds_w, disp_w, 4'b0001, disp(0, 1, 0));
        end
        cycles(4);
        checks++;
        if (disp_w !== disp(0, 0, 99)) begin
            errors++; $display("FAIL first_tick got %h exp %h", disp_w, disp(0, 0, 99));
        end
        cycles(395);
        checks++;
        if (disp_w !== disp(0, 0, 1) || leds_w !== 4'b0001) begin
            errors++; $display("FAIL tick_99 got leds %b disp %h exp leds %b disp %h", leds_w, disp_w, 4'b0001, disp(0, 0, 1));
        end
        cycles(1);
        checks++;
        if (disp_w !== disp(0, 0, 0) || leds_w !== 4'b1100) begin
            errors++; $display("FAIL expired got leds %b disp %h exp leds %b disp %h", leds_w, disp_w, 4'b1100, disp(0, 0, 0));
        end
        cycles(4);
        checks++;
        if (led3 !== 1'b1) begin
            errors++; $display("FAIL blink_t1 got %b exp %b", led3, 1'b1);
        end
        cycles(4);
        checks++;
        if (led3 !== 1'b0) begin
            errors++; $display("FAIL blink_t2 got %b exp %b", led3, 1'b0);
        end
        cycles(8);
        checks++;
        if (led3 !== 1'b1 || led2 !== 1'b1) begin
            errors++; $display("FAIL blink_t4 got led3 %b led2 %b exp 1 1", led3, led2);
        end
    endtask

    task automatic test_expired_ack();
        cycles(6);
        press(3'b100);
        checks++;
        if (disp_w !== disp(0, 1, 0) || leds_w !== 4'b0000) begin
            errors++; $display("FAIL ack_idle got leds %b disp %h exp leds %b disp %h", leds_w, disp_w, 4'b0000, disp(0, 1, 0));
        end
    endtask

    task automatic test_pause();
        do_reset();
        press(3'b010); cycles(6);
        press(3'b100);
        cycles(4);
        checks++;
        if (disp_w !== disp(0, 59, 99)) begin
            errors++; $display("FAIL min_borrow got %h exp %h", disp_w, disp(0, 59, 99));
        end
        press(3'b100);
        checks++;
        if (leds_w !== 4'b0010 || disp_w !== disp(0, 59, 98)) begin
            errors++; $display("FAIL pause got leds %b disp %h exp leds %b disp %h", leds_w, disp_w, 4'b0010, disp(0, 59, 98));
        end
        cycles(200);
        checks++;
        if (disp_w !== disp(0, 59, 98)) begin
            errors++; $display("FAIL pause_frozen got %h exp %h", disp_w, disp(0, 59, 98));
        end
        press(3'b100);
        checks++;
        if (leds_w !== 4'b0001) begin
            errors++; $display("FAIL resume_leds got %b exp %b", leds_w, 4'b0001);
        end
        cycles(3);
        checks++;
        if (disp_w !== disp(0, 59, 98)) begin
            errors++; $display("FAIL resume_full_tick got %h exp %h", disp_w, disp(0, 59, 98));
        end
        cycles(1);
        checks++;
        if (disp_w !== disp(0, 59, 97)) begin
            errors++; $display("FAIL resume_tick got %h exp %h", disp_w, disp(0, 59, 97));
        end
    endtask

    task automatic test_set_in_run();
        do_reset();
        press(3'b010); cycles(6);
        press(3'b100);
        cycles(6);
        press(3'b011);
        checks++;
        if (disp_w !== disp(0, 59, 97) || leds_w !== 4'b0001) begin
            errors++; $display("FAIL set_in_run got leds %b disp %h exp leds %b disp %h", leds_w, disp_w, 4'b0001, disp(0, 59, 97));
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        press(3'b010); cycles(6);
        press(3'b100);
        cycles(10);
        #2 k_reset = 1'b0;
        #1;
        checks++;
        if (disp_w !== disp(0, 0, 0) || leds_w !== 4'b0000) begin
            errors++; $display("FAIL async_reset got leds %b disp %h exp leds %b disp %h", leds_w, disp_w, 4'b0000, disp(0, 0, 0));
        end
        cycles(2);
        k_reset = 1'b1;
        cycles(20);
        checks++;
        if (disp_w !== disp(0, 0, 0) || leds_w !== 4'b0000) begin
            errors++; $display("FAIL post_reset got leds %b disp %h exp leds %b disp %h", leds_w, disp_w, 4'b0000, disp(0, 0, 0));
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_wrap();
        test_countdown();
        test_expired_ack();
        test_pause();
        test_set_in_run();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
